// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported SRAM between the fetch stage and the data memory stage.
// Data requests win over fetch; each access holds the SRAM for WAIT_CYCLES cycles, then acks for one cycle.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_rd_en,
   input  logic              mem_wr_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              freeze,
   output logic              proto_err
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state;
   logic [3:0] cnt;
   logic gnt_mem;
   logic mem_req;
   assign mem_req = mem_rd_en | mem_wr_en;
   assign freeze = (if_req & ~if_ack) | (mem_req & ~mem_ack);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         gnt_mem    <= 1'b0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         if_ack     <= 1'b0;
         mem_ack    <= 1'b0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
         proto_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mem_req | if_req) begin
               gnt_mem    <= mem_req;
               sram_addr  <= mem_req ? mem_addr : if_addr;
               sram_wdata <= mem_wdata;
               sram_en    <= 1'b1;
               sram_we    <= mem_wr_en;
               proto_err  <= proto_err | (mem_rd_en & mem_wr_en);
               cnt        <= 4'(WAIT_CYCLES - 1);
               state      <= ACCESS;
            end
            ACCESS: if (cnt == 4'd0) begin
               // writes leave mem_rdata holding the last read value
               if (gnt_mem && !sram_we) mem_rdata <= sram_rdata;
               if (!gnt_mem) if_rdata <= sram_rdata;
               mem_ack <= gnt_mem;
               if_ack  <= ~gnt_mem;
               sram_en <= 1'b0;
               sram_we <= 1'b0;
               state   <= DONE;
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: begin
               if_ack  <= 1'b0;
               mem_ack <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule
